coord_addr_pipe: RTL and testbench

- Parametrised, pipelined successor to the camera-path coordinate-to-address converter.
- Maps pixel coordinate (X,Y) to a linear frame-buffer word address: ADDR = BANK*H_RES*V_RES + Y*H_RES + X.
- Adds valid/ready flow control, out-of-range detection and double-buffer bank selection.
- Sits between the CCD/VGA coordinate counters and the SDRAM/SRAM frame-buffer write/read controllers.

---
 rtl/coord_addr_pipe.sv | 101 ++++++++++
 tb/tb_coord_addr_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coord_addr_pipe.sv
// rtl/coord_addr_pipe.sv - two-stage (X,Y) to frame-buffer address pipeline with valid/ready, OOR flag and double-buffer bank.
// Optional COORD_MIRROR_EN adds iMirror (horizontal mirror of in-range columns).
module coord_addr_pipe #(
  parameter int X_W        = 13,
  parameter int Y_W        = 13,
  parameter int ADDR_W     = 20,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int DOUBLE_BUF = 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [X_W-1:0]    iX,
  input  logic [Y_W-1:0]    iY,
  input  logic              iValid,
  output logic              oReady,
  input  logic              iSwap,
`ifdef COORD_MIRROR_EN
  input  logic              iMirror,
`endif
  output logic [ADDR_W-1:0] oAddr,
  output logic              oValid,
  input  logic              iReady,
  output logic              oOOR,
  output logic              oBank
);

  localparam logic [31:0]       LP_HRES32 = 32'(H_RES);
  localparam logic [31:0]       LP_VRES32 = 32'(V_RES);
  localparam logic [ADDR_W-1:0] LP_H_A    = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] LP_FRAME  = ADDR_W'(H_RES * V_RES);
  localparam logic [X_W-1:0]    LP_XMAX   = X_W'(H_RES - 1);

  logic              r_bank;
  logic              r_s1_valid;
  logic [X_W-1:0]    r_s1_x;
  logic              r_s1_oor;
  logic              r_s1_bank;
  logic [ADDR_W-1:0] r_s1_row;
  logic              r_s2_valid;
  logic [ADDR_W-1:0] r_addr;
  logic              r_oor;

  logic              w_advance;
  logic              w_x_oor;
  logic              w_oor;
  logic              w_mirror;
  logic [X_W-1:0]    w_x_eff;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_sum;

`ifdef COORD_MIRROR_EN
  assign w_mirror = iMirror;
`else
  assign w_mirror = 1'b0;
`endif

  assign w_advance = iReady | ~r_s2_valid;
  assign w_x_oor   = 32'(iX) >= LP_HRES32;
  assign w_oor     = w_x_oor | (32'(iY) >= LP_VRES32);
  // Range check above uses the raw column; mirroring only touches in-range columns.
  assign w_x_eff   = (w_mirror && !w_x_oor) ? (LP_XMAX - iX) : iX;
  assign w_row     = ADDR_W'(iY) * LP_H_A;
  assign w_sum     = (r_s1_bank ? LP_FRAME : '0) + r_s1_row + ADDR_W'(r_s1_x);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_bank     <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_oor   <= 1'b0;
      r_s1_bank  <= 1'b0;
      r_s1_row   <= '0;
      r_s2_valid <= 1'b0;
      r_addr     <= '0;
      r_oor      <= 1'b0;
    end else begin
      if (iSwap && (DOUBLE_BUF != 0)) begin
        r_bank <= ~r_bank;
      end
      // The bank bit is captured with the coordinate so in-flight beats keep their bank.
      if (w_advance) begin
        r_s1_valid <= iValid;
        r_s1_x     <= w_x_eff;
        r_s1_oor   <= w_oor;
        r_s1_bank  <= r_bank;
        r_s1_row   <= w_row;
        r_s2_valid <= r_s1_valid;
        r_addr     <= (r_s1_valid && !r_s1_oor) ? w_sum : '0;
        r_oor      <= r_s1_valid & r_s1_oor;
      end
    end
  end

  assign oReady = w_advance;
  assign oValid = r_s2_valid;
  assign oAddr  = r_addr;
  assign oOOR   = r_oor;
  assign oBank  = r_bank;

endmodule

// File: tb/tb_coord_addr_pipe.sv
// tb/tb_coord_addr_pipe.sv - self-checking bench for coord_addr_pipe (scoreboard model plus directed literals).
module tb_coord_addr_pipe;

  localparam int H = 640;
  localparam int V = 480;

  logic        iCLK    = 1'b0;
  logic        iRST    = 1'b1;
  logic [12:0] iX      = '0;
  logic [12:0] iY      = '0;
  logic        iValid  = 1'b0;
  logic        iSwap   = 1'b0;
  logic        iReady  = 1'b1;
  logic        iMirror = 1'b0;
  logic        oReady;
  logic        oValid;
  logic        oOOR;
  logic        oBank;
  logic [19:0] oAddr;

  coord_addr_pipe dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iX      (iX),
    .iY      (iY),
    .iValid  (iValid),
    .oReady  (oReady),
    .iSwap   (iSwap),
`ifdef COORD_MIRROR_EN
    .iMirror (iMirror),
`endif
    .oAddr   (oAddr),
    .oValid  (oValid),
    .iReady  (iReady),
    .oOOR    (oOOR),
    .oBank   (oBank)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int addr;
    bit oor;
  } beat_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  int    obs_addr[$];
  bit    obs_oor[$];
  bit    m_bank     = 1'b0;
  bit    rand_ready = 1'b0;
  bit    prev_stall = 1'b0;
  logic [19:0] prev_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t model(input int x, input int y, input bit bank, input bit mir);
    beat_t b;
    b.oor = (x >= H) || (y >= V);
    if (b.oor) b.addr = 0;
    else b.addr = (bank ? H * V : 0) + y * H + (mir ? (H - 1 - x) : x);
    return b;
  endfunction

  // Scoreboard: every cycle, sampled mid-cycle away from the rising edge.
  always @(negedge iCLK) begin
    if (iRST) begin
      exp_q.delete();
      m_bank     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("oready_rule", oReady, iReady || !oValid);
      check("obank", oBank, m_bank);
      if (prev_stall) begin
        check("stall_valid", oValid, 1);
        check("stall_addr", oAddr, prev_addr);
      end
      if (oValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", oValid, 0);
        end else begin
          check("addr", oAddr, exp_q[0].addr);
          check("oor", oOOR, exp_q[0].oor);
          if (iReady) begin
            obs_addr.push_back(int'(oAddr));
            obs_oor.push_back(oOOR);
            void'(exp_q.pop_front());
          end
        end
      end
      prev_stall = oValid && !iReady;
      prev_addr  = oAddr;
      if (iValid && (iReady || !oValid))
        exp_q.push_back(model(int'(iX), int'(iY), m_bank, iMirror));
      if (iSwap) m_bank = ~m_bank;
    end
  end

  always @(posedge iCLK) begin
    if (rand_ready) begin
      #1;
      iReady = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input int x, input int y, input bit mir, input bit swp);
    int guard;
    iX      = 13'(x);
    iY      = 13'(y);
    iMirror = mir;
    iSwap   = swp;
    iValid  = 1'b1;
    guard   = 0;
    @(negedge iCLK);
    while (!(iReady || !oValid) && guard < 50) begin
      @(negedge iCLK);
      guard++;
    end
    if (guard >= 50) check("send_timeout", guard, 0);
    @(posedge iCLK);
    #1;
    iValid  = 1'b0;
    iSwap   = 1'b0;
    iMirror = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic swap_pulse();
    iSwap = 1'b1;
    @(posedge iCLK);
    #1;
    iSwap = 1'b0;
  endtask

  task automatic expect_obs(input string tag, input int ea[4], input bit eo[4], input int n);
    check({tag, "_count"}, obs_addr.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < obs_addr.size()) begin
        check({tag, "_addr"}, obs_addr[i], ea[i]);
        check({tag, "_oor"}, obs_oor[i], eo[i]);
      end
    end
    obs_addr.delete();
    obs_oor.delete();
  endtask

  task automatic latency_probe(input int x, input int y);
    int n;
    send(x, y, 1'b0, 1'b0);
    n = 0;
    while (n < 10) begin
      @(negedge iCLK);
      n++;
      if (oValid) break;
    end
    check("latency", n, 2);
    idle(3);
    obs_addr.delete();
    obs_oor.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  drain;
    int  rx, ry;
    bit  rm;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    check("rst_valid", oValid, 0);
    check("rst_addr", oAddr, 0);
    check("rst_oor", oOOR, 0);
    check("rst_bank", oBank, 0);
    @(posedge iCLK);
    #1;
    iRST = 1'b0;

    latency_probe(7, 0);

    send(1, 0, 0, 0); send(5, 1, 0, 0); send(200, 200, 0, 0); send(0, 120, 0, 0);
    idle(4);
    expect_obs("basic", '{1, 645, 128200, 76800}, '{0, 0, 0, 0}, 4);

    swap_pulse();
    @(negedge iCLK);
    check("bank_after_swap", oBank, 1);
    @(posedge iCLK); #1;
    send(0, 0, 0, 0); send(639, 479, 0, 0); send(3, 0, 0, 1); send(3, 0, 0, 0);
    idle(4);
    expect_obs("bank", '{307200, 614399, 307203, 3}, '{0, 0, 0, 0}, 4);

    send(640, 0, 0, 0); send(0, 480, 0, 0);
    idle(4);
    expect_obs("range", '{0, 0, 0, 0}, '{1, 1, 0, 0}, 2);

    send(10, 10, 0, 0); send(11, 10, 0, 0);
    iReady = 1'b0;
    fork
      begin
        send(12, 10, 0, 0);
        send(13, 10, 0, 0);
      end
      begin
        repeat (3) begin
          @(negedge iCLK);
          check("stall_oready", oReady, 0);
        end
        @(posedge iCLK);
        #1;
        iReady = 1'b1;
      end
    join
    idle(5);
    expect_obs("stall", '{6410, 6411, 6412, 6413}, '{0, 0, 0, 0}, 4);

`ifdef COORD_MIRROR_EN
    send(0, 0, 1, 0); send(639, 1, 1, 0); send(700, 0, 1, 0);
    idle(4);
    expect_obs("mirror", '{639, 640, 0, 0}, '{0, 0, 1, 0}, 3);
`endif

    swap_pulse();
    send(1, 1, 0, 0); send(2, 2, 0, 0);
    #2;
    iRST = 1'b1;
    #1;
    check("async_rst_valid", oValid, 0);
    check("async_rst_bank", oBank, 0);
    @(posedge iCLK);
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    obs_addr.delete();
    obs_oor.delete();
    latency_probe(5, 5);

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        rx = int'($urandom_range(0, 710));
        ry = int'($urandom_range(0, 500));
`ifdef COORD_MIRROR_EN
        rm = bit'($urandom_range(0, 1));
`else
        rm = 1'b0;
`endif
        send(rx, ry, rm, $urandom_range(0, 7) == 0);
      end
    end
    rand_ready = 1'b0;
    @(posedge iCLK);
    #2;
    iReady = 1'b1;
    drain = 0;
    while ((exp_q.size() != 0 || oValid) && drain < 50) begin
      @(posedge iCLK);
      drain++;
    end
    @(negedge iCLK);
    check("drain_empty", exp_q.size(), 0);
    check("drain_valid", oValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
